digit_string_renderer: RTL and testbench

//  Pipelined renderer for a row of NUM_DIGITS BCD digits on the display pixel scan.
//  - Takes the pixel-coordinate stream from the display timing block.
//  - Returns a 6-bit colour per pixel, 2 cycles later.
//  - Replaces the per-digit glyph ROMs: all 10 glyphs come from one 7-segment cell table, scaled and positioned.
//  - Digit values are double-buffered and commit only at frame start, so a frame never tears.

---
 rtl/digit_string_renderer_if.sv | 27 ++
 rtl/digit_string_renderer.sv | 201 ++++++++++++++++++++
 tb/tb_digit_string_renderer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/digit_string_renderer_if.sv
// Pixel-stream, digit-update and colour-output bundle for digit_string_renderer.
// The master side is the display timing/control logic; the slave side is the renderer.
interface digit_string_renderer_if #(
  parameter int unsigned XW         = 10,
  parameter int unsigned NUM_DIGITS = 4
);
  logic [XW-1:0]           pix_x;
  logic [XW-1:0]           pix_y;
  logic                    pix_valid;
  logic                    frame_start;
  logic                    digits_wr;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    blank_lz;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [5:0]              color;
  logic                    color_valid;

  modport master (
    output pix_x, pix_y, pix_valid, frame_start, digits_wr, digits_in, blank_lz, blink_mask,
    input  color, color_valid
  );

  modport slave (
    input  pix_x, pix_y, pix_valid, frame_start, digits_wr, digits_in, blank_lz, blink_mask,
    output color, color_valid
  );
endinterface

// File: rtl/digit_string_renderer.sv
// Two-stage pixel pipeline drawing a row of BCD digits from one scaled 7-segment cell.
// Optional per-digit blinking is built only when `define DIGIT_BLINK_EN is set.
module digit_string_renderer #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCALE_LOG2   = 1,
  parameter int unsigned ORIGIN_X     = 0,
  parameter int unsigned ORIGIN_Y     = 0,
  parameter int unsigned XW           = 10,
  parameter logic [5:0]  FG           = 6'b000000,
  parameter logic [5:0]  BG           = 6'b111111,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input logic                    clk,
  input logic                    reset_n,
  digit_string_renderer_if.slave bus
);

  localparam int unsigned IDXW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DW      = 4 * NUM_DIGITS;
  localparam int unsigned XE      = XW + 1;
  localparam int unsigned FIELD_W = NUM_DIGITS << (3 + SCALE_LOG2);
  localparam int unsigned FIELD_H = 16 << SCALE_LOG2;

  // Segment bits ordered {a,b,c,d,e,f,g}; codes 10-15 are blank.
  function automatic logic [6:0] seg_map(input logic [3:0] d);
    case (d)
      4'd0:    seg_map = 7'b1111110;
      4'd1:    seg_map = 7'b0110000;
      4'd2:    seg_map = 7'b1101101;
      4'd3:    seg_map = 7'b1111001;
      4'd4:    seg_map = 7'b0110011;
      4'd5:    seg_map = 7'b1011011;
      4'd6:    seg_map = 7'b1011111;
      4'd7:    seg_map = 7'b1110000;
      4'd8:    seg_map = 7'b1111111;
      4'd9:    seg_map = 7'b1111011;
      default: seg_map = 7'b0000000;
    endcase
  endfunction

  logic [XE-1:0]   w_dx_ext;
  logic [XE-1:0]   w_dy_ext;
  logic [XW-1:0]   w_dx;
  logic [XW-1:0]   w_dy;
  logic            w_in_field;
  logic [IDXW-1:0] w_idx;
  logic [2:0]      w_col;
  logic [3:0]      w_row;

  // Stage 1 address decode; the borrow bit flags pixels left of / above the origin.
  assign w_dx_ext   = {1'b0, bus.pix_x} - XE'(ORIGIN_X);
  assign w_dy_ext   = {1'b0, bus.pix_y} - XE'(ORIGIN_Y);
  assign w_dx       = w_dx_ext[XW-1:0];
  assign w_dy       = w_dy_ext[XW-1:0];
  assign w_in_field = !w_dx_ext[XW] && !w_dy_ext[XW] &&
                      (32'(w_dx) < FIELD_W) && (32'(w_dy) < FIELD_H);
  assign w_idx      = IDXW'(NUM_DIGITS - 1) - IDXW'(w_dx >> (3 + SCALE_LOG2));
  assign w_col      = 3'(w_dx >> SCALE_LOG2);
  assign w_row      = 4'(w_dy >> SCALE_LOG2);

  logic            r_v1;
  logic            r_in1;
  logic [IDXW-1:0] r_idx1;
  logic [2:0]      r_col1;
  logic [3:0]      r_row1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1   <= 1'b0;
      r_in1  <= 1'b0;
      r_idx1 <= '0;
      r_col1 <= '0;
      r_row1 <= '0;
    end else begin
      r_v1   <= bus.pix_valid;
      r_in1  <= w_in_field;
      r_idx1 <= w_idx;
      r_col1 <= w_col;
      r_row1 <= w_row;
    end
  end

  logic [DW-1:0]         r_active;
  logic [DW-1:0]         r_pending;
  logic                  r_pend_flag;
  logic [NUM_DIGITS-1:0] r_lz;
  logic                  w_commit;
  logic [DW-1:0]         w_commit_val;
  logic [NUM_DIGITS-1:0] w_lz_next;
  logic                  w_seen;

  assign w_commit     = bus.frame_start && (bus.digits_wr || r_pend_flag);
  assign w_commit_val = bus.digits_wr ? bus.digits_in : r_pending;

  // Leading-zero mask, scanned from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    w_lz_next = '0;
    w_seen    = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (w_commit_val[4*i +: 4] != 4'd0) w_seen = 1'b1;
      w_lz_next[i] = bus.blank_lz && !w_seen;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active    <= '0;
      r_pending   <= '0;
      r_pend_flag <= 1'b0;
      r_lz        <= '0;
    end else begin
      if (bus.digits_wr) r_pending <= bus.digits_in;
      if (bus.frame_start)    r_pend_flag <= 1'b0;
      else if (bus.digits_wr) r_pend_flag <= 1'b1;
      if (w_commit) begin
        r_active <= w_commit_val;
        r_lz     <= w_lz_next;
      end
    end
  end

  logic [NUM_DIGITS-1:0] w_blink_vec;

`ifdef DIGIT_BLINK_EN
  localparam int unsigned CNTW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNTW-1:0] r_blink_cnt;
  logic            r_blink_phase;

  // Frame counter; the phase flips every BLINK_FRAMES frame starts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (bus.frame_start) begin
      if (r_blink_cnt == CNTW'(BLINK_FRAMES - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + CNTW'(1);
      end
    end
  end

  assign w_blink_vec = {NUM_DIGITS{r_blink_phase}} & bus.blink_mask;
`else
  logic w_unused_blink;

  assign w_blink_vec    = '0;
  assign w_unused_blink = ^{bus.blink_mask, 32'(BLINK_FRAMES)};
`endif

  logic [3:0] w_digit;
  logic       w_blank;
  logic [6:0] w_seg;
  logic       w_ch;
  logic       w_top;
  logic       w_bot;
  logic       w_ink;

  // Stage 2 digit select and cell ink test.
  always_comb begin
    w_digit = 4'd0;
    w_blank = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx1 == IDXW'(i)) begin
        w_digit = r_active[4*i +: 4];
        w_blank = r_lz[i] | w_blink_vec[i];
      end
    end
  end

  assign w_seg = seg_map(w_digit);
  assign w_ch  = (r_col1 >= 3'd1) && (r_col1 <= 3'd6);
  assign w_top = (r_row1 >= 4'd1) && (r_row1 <= 4'd8);
  assign w_bot = (r_row1 >= 4'd7) && (r_row1 <= 4'd14);
  assign w_ink = (w_seg[6] && w_ch && (r_row1 == 4'd1  || r_row1 == 4'd2))  ||
                 (w_seg[0] && w_ch && (r_row1 == 4'd7  || r_row1 == 4'd8))  ||
                 (w_seg[3] && w_ch && (r_row1 == 4'd13 || r_row1 == 4'd14)) ||
                 (w_seg[1] && (r_col1 == 3'd1) && w_top) ||
                 (w_seg[5] && (r_col1 == 3'd6) && w_top) ||
                 (w_seg[2] && (r_col1 == 3'd1) && w_bot) ||
                 (w_seg[4] && (r_col1 == 3'd6) && w_bot);

  logic [5:0] r_color;
  logic       r_color_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_color       <= BG;
      r_color_valid <= 1'b0;
    end else begin
      r_color       <= (r_v1 && r_in1 && !w_blank && w_ink) ? FG : BG;
      r_color_valid <= r_v1;
    end
  end

  assign bus.color       = r_color;
  assign bus.color_valid = r_color_valid;

endmodule

// File: tb/tb_digit_string_renderer.sv
// Randomised self-checking bench for digit_string_renderer against a geometric reference model.
// A second instance with a shifted origin shares the same stimulus.
module tb_digit_string_renderer;

  localparam int unsigned XW   = 10;
  localparam int unsigned ND   = 4;
  localparam int unsigned BF   = 2;
  localparam int          OX2  = 16;
  localparam int          OY2  = 4;
  localparam int          MAXS = 96;
  localparam logic [5:0]  FGC  = 6'h00;
  localparam logic [5:0]  BGC  = 6'h3F;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  digit_string_renderer_if #(.XW(XW), .NUM_DIGITS(ND)) bus ();
  digit_string_renderer_if #(.XW(XW), .NUM_DIGITS(ND)) bus_off ();

  assign bus_off.pix_x       = bus.pix_x;
  assign bus_off.pix_y       = bus.pix_y;
  assign bus_off.pix_valid   = bus.pix_valid;
  assign bus_off.frame_start = bus.frame_start;
  assign bus_off.digits_wr   = bus.digits_wr;
  assign bus_off.digits_in   = bus.digits_in;
  assign bus_off.blank_lz    = bus.blank_lz;
  assign bus_off.blink_mask  = bus.blink_mask;

  digit_string_renderer #(
    .NUM_DIGITS(ND), .SCALE_LOG2(1), .ORIGIN_X(0), .ORIGIN_Y(0), .XW(XW),
    .FG(FGC), .BG(BGC), .BLINK_FRAMES(BF)
  ) u_dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  digit_string_renderer #(
    .NUM_DIGITS(ND), .SCALE_LOG2(1), .ORIGIN_X(OX2), .ORIGIN_Y(OY2), .XW(XW),
    .FG(FGC), .BG(BGC), .BLINK_FRAMES(BF)
  ) u_dut_off (.clk(clk), .reset_n(reset_n), .bus(bus_off));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [15:0] m_active;
  logic [15:0] m_pend;
  bit          m_flag;
  bit          m_lz [ND];
  int          m_frames;
  logic [3:0]  cur_mask;

  string segs [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                       "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  // Stream stimulus and results
  int          s_x   [MAXS];
  int          s_y   [MAXS];
  logic        s_v   [MAXS];
  logic        s_fs  [MAXS];
  logic        s_wr  [MAXS];
  logic [15:0] s_din [MAXS];
  logic        s_blz [MAXS];
  logic [5:0]  exp_c [MAXS];
  logic [5:0]  exp_c2[MAXS];
  logic        exp_v [MAXS];
  logic [5:0]  obs_c [MAXS];
  logic [5:0]  obs_c2[MAXS];
  logic        obs_v [MAXS];

  function automatic bit seg_hit(input byte s, input int c, input int r);
    case (s)
      "a":     return r >= 1  && r <= 2  && c >= 1 && c <= 6;
      "g":     return r >= 7  && r <= 8  && c >= 1 && c <= 6;
      "d":     return r >= 13 && r <= 14 && c >= 1 && c <= 6;
      "f":     return c == 1 && r >= 1 && r <= 8;
      "b":     return c == 6 && r >= 1 && r <= 8;
      "e":     return c == 1 && r >= 7 && r <= 14;
      "c":     return c == 6 && r >= 7 && r <= 14;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit glyph_ink(input int d, input int c, input int r);
    string s;
    if (d > 9) return 1'b0;
    s = segs[d];
    for (int i = 0; i < s.len(); i++)
      if (seg_hit(s.getc(i), c, r)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit blink_off(input int di);
`ifdef DIGIT_BLINK_EN
    return cur_mask[di] && (((m_frames / int'(BF)) % 2) == 1);
`else
    return 1'b0 && (di < 0);
`endif
  endfunction

  function automatic logic [5:0] model_color(input int x, input int y, input int ox, input int oy);
    int dx, dy, di, c, r, d;
    if (x < ox || y < oy) return BGC;
    dx = x - ox;
    dy = y - oy;
    if (dx >= int'(ND) * 16 || dy >= 32) return BGC;
    di = int'(ND) - 1 - dx / 16;
    c  = (dx / 2) % 8;
    r  = (dy / 2) % 16;
    d  = int'(m_active[4*di +: 4]);
    if (m_lz[di] || blink_off(di)) return BGC;
    return glyph_ink(d, c, r) ? FGC : BGC;
  endfunction

  task automatic model_commit(input logic [15:0] v, input logic blz);
    int msd;
    m_active = v;
    msd = 0;
    for (int i = 0; i < int'(ND); i++)
      if (v[4*i +: 4] != 4'd0) msd = i;
    for (int i = 0; i < int'(ND); i++)
      m_lz[i] = blz && (i > msd);
  endtask

  task automatic model_reset();
    m_active = '0;
    m_pend   = '0;
    m_flag   = 1'b0;
    m_frames = 0;
    for (int i = 0; i < int'(ND); i++) m_lz[i] = 1'b0;
  endtask

  task automatic model_cycle(input logic fs, input logic wr, input logic [15:0] din, input logic blz);
    if (fs) begin
      m_frames++;
      if (wr)          model_commit(din, blz);
      else if (m_flag) model_commit(m_pend, blz);
      m_flag = 1'b0;
    end else if (wr) begin
      m_pend = din;
      m_flag = 1'b1;
    end
  endtask

  task automatic drive_idle();
    bus.pix_valid   = 1'b0;
    bus.frame_start = 1'b0;
    bus.digits_wr   = 1'b0;
  endtask

  task automatic set_px(input int k, input int x, input int y, input logic fs,
                        input logic wr, input logic [15:0] din, input logic blz);
    s_x[k] = x; s_y[k] = y; s_v[k] = 1'b1;
    s_fs[k] = fs; s_wr[k] = wr; s_din[k] = din; s_blz[k] = blz;
  endtask

  task automatic fill_random(input int from, input int to, input bit ctl, input logic blz);
    for (int k = from; k < to; k++) begin
      s_x[k]   = int'($urandom_range(0, 95));
      s_y[k]   = int'($urandom_range(0, 47));
      s_v[k]   = 1'($urandom_range(0, 1));
      s_fs[k]  = ctl && ($urandom_range(0, 9) == 0);
      s_wr[k]  = ctl && ($urandom_range(0, 7) == 0);
      s_din[k] = 16'($urandom);
      s_blz[k] = ctl ? 1'($urandom_range(0, 1)) : blz;
    end
  endtask

  // Drive cnt back-to-back cycles; results of cycle k are sampled two falling edges later.
  task automatic run_stream(input int cnt);
    for (int k = 0; k < cnt + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        obs_c[k-2]  = bus.color;
        obs_v[k-2]  = bus.color_valid;
        obs_c2[k-2] = bus_off.color;
      end
      if (k < cnt) begin
        bus.pix_x       = XW'(s_x[k]);
        bus.pix_y       = XW'(s_y[k]);
        bus.pix_valid   = s_v[k];
        bus.frame_start = s_fs[k];
        bus.digits_wr   = s_wr[k];
        bus.digits_in   = s_din[k];
        bus.blank_lz    = s_blz[k];
        bus.blink_mask  = cur_mask;
        model_cycle(s_fs[k], s_wr[k], s_din[k], s_blz[k]);
        exp_v[k]  = s_v[k];
        exp_c[k]  = s_v[k] ? model_color(s_x[k], s_y[k], 0, 0) : BGC;
        exp_c2[k] = s_v[k] ? model_color(s_x[k], s_y[k], OX2, OY2) : BGC;
      end else begin
        drive_idle();
      end
    end
  endtask

  task automatic test_reset();
    bus.pix_x = '0; bus.pix_y = '0; bus.digits_in = '0; bus.blank_lz = 1'b0;
    cur_mask = 4'b0000; bus.blink_mask = cur_mask;
    drive_idle();
    model_reset();
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.color !== BGC) begin n_errors++; $display("FAIL reset_color got %h exp %h", bus.color, BGC); end
    n_checks++;
    if (bus.color_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b exp 0", bus.color_valid); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.pix_x = XW'(50); bus.pix_y = XW'(2); bus.pix_valid = 1'b1;
    end
    @(negedge clk);
    bus.pix_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.color !== BGC) begin n_errors++; $display("FAIL midreset_color got %h exp %h", bus.color, BGC); end
    n_checks++;
    if (bus.color_valid !== 1'b0 || bus_off.color_valid !== 1'b0) begin
      n_errors++; $display("FAIL midreset_valid got %b/%b exp 0", bus.color_valid, bus_off.color_valid);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      set_px(i, 2 + 16 * i, 2, 1'b0, 1'b0, 16'h0, 1'b0);
      set_px(i + 4, 6 + 16 * i, 8, 1'b0, 1'b0, 16'h0, 1'b0);
    end
    fill_random(8, 24, 1'b0, 1'b0);
    run_stream(24);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs_c[i] !== FGC || obs_c[i+4] !== BGC) begin
        n_errors++; $display("FAIL post_reset_zero digit %0d got %h/%h exp %h/%h", 3 - i, obs_c[i], obs_c[i+4], FGC, BGC);
      end
    end
    for (int k = 0; k < 24; k++) begin
      n_checks++;
      if (obs_v[k] !== exp_v[k]) begin n_errors++; $display("FAIL reset_stream_valid k=%0d got %b exp %b", k, obs_v[k], exp_v[k]); end
      n_checks++;
      if (obs_c[k] !== exp_c[k]) begin n_errors++; $display("FAIL reset_stream_color k=%0d got %h exp %h", k, obs_c[k], exp_c[k]); end
      n_checks++;
      if (obs_c2[k] !== exp_c2[k]) begin n_errors++; $display("FAIL reset_stream_off k=%0d got %h exp %h", k, obs_c2[k], exp_c2[k]); end
    end
  endtask

  task automatic test_glyph();
    set_px(0, 50, 2, 1'b1, 1'b1, 16'h0009, 1'b0);
    set_px(1, 54, 8, 1'b0, 1'b0, 16'h0000, 1'b0);
    set_px(2, 50, 2, 1'b0, 1'b1, 16'h0001, 1'b0);
    set_px(3, 50, 2, 1'b0, 1'b0, 16'h0000, 1'b0);
    set_px(4, 50, 2, 1'b1, 1'b0, 16'h0000, 1'b0);
    set_px(5, 50, 2, 1'b0, 1'b0, 16'h0000, 1'b0);
    fill_random(6, 30, 1'b0, 1'b0);
    run_stream(30);
    n_checks++;
    if (obs_c[0] !== 6'h00) begin n_errors++; $display("FAIL glyph9_ink got %h exp 00", obs_c[0]); end
    n_checks++;
    if (obs_c[1] !== 6'h3F) begin n_errors++; $display("FAIL glyph9_bg got %h exp 3f", obs_c[1]); end
    n_checks++;
    if (obs_c[3] !== 6'h00) begin n_errors++; $display("FAIL no_tear_hold got %h exp 00", obs_c[3]); end
    n_checks++;
    if (obs_c[4] !== 6'h3F || obs_c[5] !== 6'h3F) begin
      n_errors++; $display("FAIL no_tear_commit got %h/%h exp 3f/3f", obs_c[4], obs_c[5]);
    end
    for (int k = 0; k < 30; k++) begin
      n_checks++;
      if (obs_v[k] !== exp_v[k]) begin n_errors++; $display("FAIL glyph_valid k=%0d got %b exp %b", k, obs_v[k], exp_v[k]); end
      n_checks++;
      if (obs_c[k] !== exp_c[k]) begin n_errors++; $display("FAIL glyph_color k=%0d got %h exp %h", k, obs_c[k], exp_c[k]); end
      n_checks++;
      if (obs_c2[k] !== exp_c2[k]) begin n_errors++; $display("FAIL glyph_off k=%0d got %h exp %h", k, obs_c2[k], exp_c2[k]); end
    end
  endtask

  task automatic test_lz();
    set_px(0, 2,  2, 1'b1, 1'b1, 16'h0042, 1'b1);
    set_px(1, 18, 2, 1'b0, 1'b0, 16'h0000, 1'b1);
    set_px(2, 34, 2, 1'b0, 1'b0, 16'h0000, 1'b1);
    set_px(3, 50, 2, 1'b0, 1'b0, 16'h0000, 1'b1);
    fill_random(4, 36, 1'b0, 1'b1);
    set_px(36, 50, 2, 1'b1, 1'b1, 16'h0000, 1'b1);
    set_px(37, 34, 2, 1'b0, 1'b0, 16'h0000, 1'b1);
    set_px(38, 2,  2, 1'b0, 1'b0, 16'h0000, 1'b1);
    fill_random(39, 56, 1'b0, 1'b1);
    run_stream(56);
    n_checks++;
    if (obs_c[0] !== BGC || obs_c[1] !== BGC) begin
      n_errors++; $display("FAIL lz_upper_blank got %h/%h exp 3f/3f", obs_c[0], obs_c[1]);
    end
    n_checks++;
    if (obs_c[2] !== FGC || obs_c[3] !== FGC) begin
      n_errors++; $display("FAIL lz_lower_draw got %h/%h exp 00/00", obs_c[2], obs_c[3]);
    end
    n_checks++;
    if (obs_c[36] !== FGC || obs_c[37] !== BGC || obs_c[38] !== BGC) begin
      n_errors++; $display("FAIL lz_all_zero got %h/%h/%h exp 00/3f/3f", obs_c[36], obs_c[37], obs_c[38]);
    end
    for (int k = 0; k < 56; k++) begin
      n_checks++;
      if (obs_v[k] !== exp_v[k]) begin n_errors++; $display("FAIL lz_valid k=%0d got %b exp %b", k, obs_v[k], exp_v[k]); end
      n_checks++;
      if (obs_c[k] !== exp_c[k]) begin n_errors++; $display("FAIL lz_color k=%0d got %h exp %h", k, obs_c[k], exp_c[k]); end
      n_checks++;
      if (obs_c2[k] !== exp_c2[k]) begin n_errors++; $display("FAIL lz_off k=%0d got %h exp %h", k, obs_c2[k], exp_c2[k]); end
    end
  endtask

  task automatic test_back_to_back();
    set_px(0, 60, 2, 1'b1, 1'b1, 16'h8888, 1'b0);
    set_px(1, 63, 2, 1'b0, 1'b0, 16'h0000, 1'b0);
    set_px(2, 64, 2, 1'b0, 1'b0, 16'h0000, 1'b0);
    set_px(3, 0,  2, 1'b0, 1'b0, 16'h0000, 1'b0);
    set_px(4, 18, 6, 1'b0, 1'b0, 16'h0000, 1'b0);
    fill_random(5, 90, 1'b1, 1'b0);
    run_stream(90);
    n_checks++;
    if (obs_c[0] !== FGC) begin n_errors++; $display("FAIL edge_x60 got %h exp 00", obs_c[0]); end
    n_checks++;
    if (obs_c[1] !== BGC || obs_c[2] !== BGC) begin
      n_errors++; $display("FAIL edge_x63_x64 got %h/%h exp 3f/3f", obs_c[1], obs_c[2]);
    end
    n_checks++;
    if (obs_c2[3] !== BGC || obs_c2[4] !== FGC) begin
      n_errors++; $display("FAIL origin_offset got %h/%h exp 3f/00", obs_c2[3], obs_c2[4]);
    end
    for (int k = 0; k < 90; k++) begin
      n_checks++;
      if (obs_v[k] !== exp_v[k]) begin n_errors++; $display("FAIL b2b_valid k=%0d got %b exp %b", k, obs_v[k], exp_v[k]); end
      n_checks++;
      if (obs_c[k] !== exp_c[k]) begin n_errors++; $display("FAIL b2b_color k=%0d got %h exp %h", k, obs_c[k], exp_c[k]); end
      n_checks++;
      if (obs_c2[k] !== exp_c2[k]) begin n_errors++; $display("FAIL b2b_off k=%0d got %h exp %h", k, obs_c2[k], exp_c2[k]); end
    end
  endtask

  task automatic test_blink();
    logic exp_fg;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    cur_mask = 4'b0001;
    for (int f = 0; f < 6; f++) begin
      set_px(3 * f,     50, 2,  (f > 0) ? 1'b1 : 1'b0, 1'b0, 16'h0000, 1'b0);
      set_px(3 * f + 1, 50, 26, 1'b0, 1'b0, 16'h0000, 1'b0);
      set_px(3 * f + 2, 2,  2,  1'b0, 1'b0, 16'h0000, 1'b0);
    end
    run_stream(18);
    for (int f = 0; f < 6; f++) begin
`ifdef DIGIT_BLINK_EN
      exp_fg = !(f == 2 || f == 3);
`else
      exp_fg = 1'b1;
`endif
      n_checks++;
      if (obs_c[3*f] !== (exp_fg ? FGC : BGC) || obs_c[3*f+1] !== (exp_fg ? FGC : BGC)) begin
        n_errors++; $display("FAIL blink_frame%0d got %h/%h exp %h", f, obs_c[3*f], obs_c[3*f+1], exp_fg ? FGC : BGC);
      end
      n_checks++;
      if (obs_c[3*f+2] !== FGC) begin n_errors++; $display("FAIL blink_other%0d got %h exp 00", f, obs_c[3*f+2]); end
    end
    for (int k = 0; k < 18; k++) begin
      n_checks++;
      if (obs_c[k] !== exp_c[k]) begin n_errors++; $display("FAIL blink_color k=%0d got %h exp %h", k, obs_c[k], exp_c[k]); end
      n_checks++;
      if (obs_c2[k] !== exp_c2[k]) begin n_errors++; $display("FAIL blink_off k=%0d got %h exp %h", k, obs_c2[k], exp_c2[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_glyph();
    test_lz();
    test_back_to_back();
    test_blink();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
